// File: rtl/konark_cluster_pkg.sv
// Shared types and constants for the Konark cluster boot controller.
// Register offsets are byte addresses with the two low bits forced to zero.
package konark_cluster_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BOOT = 3'd1,
    ST_WAKE = 3'd2,
    ST_RUN  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [4:0] REG_BOOT_ADDR = 5'h00;
  localparam logic [4:0] REG_CORE_MASK = 5'h04;
  localparam logic [4:0] REG_CTRL      = 5'h08;
  localparam logic [4:0] REG_STATUS    = 5'h0C;
  localparam logic [4:0] REG_RETCODE   = 5'h10;
  localparam logic [4:0] REG_TIMEOUT   = 5'h14;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;

  localparam int STATUS_STATE_LSB   = 0;
  localparam int STATUS_DONE_BIT    = 3;
  localparam int STATUS_ERR_BIT     = 4;
  localparam int STATUS_TIMEOUT_BIT = 5;

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic        write;
    logic [31:0] wdata;
  } reg_req_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] rdata;
  } reg_rsp_t;

endpackage

// File: rtl/konark_cluster_reg_if.sv
// Host register port: configuration storage, read mux and a one-cycle response.
// Configuration writes are ignored while a run is in progress.
module konark_cluster_reg_if
  import konark_cluster_pkg::*;
#(
  parameter int NrCores      = 9,
  parameter int TimeoutWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    reg_req_valid_i,
  input  logic [4:0]              reg_addr_i,
  input  logic                    reg_write_i,
  input  logic [31:0]             reg_wdata_i,
  output logic                    reg_rsp_valid_o,
  output logic [31:0]             reg_rdata_o,
  input  logic                    busy_i,
  input  logic [31:0]             status_i,
  input  logic [31:0]             retcode_i,
  output logic [31:0]             boot_addr_o,
  output logic [NrCores-1:0]      core_mask_o,
  output logic [TimeoutWidth-1:0] timeout_o,
  output logic                    start_o,
  output logic                    abort_o
);

  reg_req_t                req;
  reg_rsp_t                rsp_q;
  logic [31:0]             boot_addr_q;
  logic [NrCores-1:0]      core_mask_q;
  logic [TimeoutWidth-1:0] timeout_q;
  logic [31:0]             rdata_mux;
  logic                    wr_en;
  logic                    unused_addr_bits;

  assign req = '{valid: reg_req_valid_i,
                 addr:  {reg_addr_i[4:2], 2'b00},
                 write: reg_write_i,
                 wdata: reg_wdata_i};
  assign unused_addr_bits = ^reg_addr_i[1:0];

  assign wr_en   = req.valid && req.write;
  assign start_o = wr_en && (req.addr == REG_CTRL) && req.wdata[CTRL_START_BIT];
  assign abort_o = wr_en && (req.addr == REG_CTRL) && req.wdata[CTRL_ABORT_BIT];

  always_comb begin
    rdata_mux = '0;
    case (req.addr)
      REG_BOOT_ADDR: rdata_mux = boot_addr_q;
      REG_CORE_MASK: rdata_mux = 32'(core_mask_q);
      REG_STATUS:    rdata_mux = status_i;
      REG_RETCODE:   rdata_mux = retcode_i;
      REG_TIMEOUT:   rdata_mux = 32'(timeout_q);
      default:       rdata_mux = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_q       <= '0;
      boot_addr_q <= '0;
      core_mask_q <= '0;
      timeout_q   <= '0;
    end else begin
      rsp_q.valid <= req.valid;
      rsp_q.rdata <= (req.valid && !req.write) ? rdata_mux : '0;
      if (wr_en && !busy_i) begin
        case (req.addr)
          REG_BOOT_ADDR: boot_addr_q <= req.wdata;
          REG_CORE_MASK: core_mask_q <= req.wdata[NrCores-1:0];
          REG_TIMEOUT:   timeout_q   <= req.wdata[TimeoutWidth-1:0];
          default:       ;
        endcase
      end
    end
  end

  assign reg_rsp_valid_o = rsp_q.valid;
  assign reg_rdata_o     = rsp_q.rdata;
  assign boot_addr_o     = boot_addr_q;
  assign core_mask_o     = core_mask_q;
  assign timeout_o       = timeout_q;

endmodule

// File: rtl/konark_cluster_boot_ctrl.sv
// Cluster bring-up sequencer: fetch enable, settle, wake pulse, wait for
// end-of-computation from every selected core, then report the outcome.
module konark_cluster_boot_ctrl
  import konark_cluster_pkg::*;
#(
  parameter int NrCores          = 9,
  parameter int BootSettleCycles = 4,
  parameter int TimeoutWidth     = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               reg_req_valid_i,
  output logic               reg_req_ready_o,
  input  logic [4:0]         reg_addr_i,
  input  logic               reg_write_i,
  input  logic [31:0]        reg_wdata_i,
  output logic               reg_rsp_valid_o,
  output logic [31:0]        reg_rdata_o,
  output logic [31:0]        boot_addr_o,
  output logic [NrCores-1:0] fetch_en_o,
  output logic [NrCores-1:0] wake_o,
  input  logic [NrCores-1:0] eoc_i,
  input  logic [31:0]        eoc_code_i,
  output logic               busy_o,
  output logic               done_irq_o
);

  localparam int SettleW = (BootSettleCycles > 1) ? $clog2(BootSettleCycles) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(BootSettleCycles - 1);

  state_e                  state_q;
  logic [NrCores-1:0]      mask_q;
  logic [NrCores-1:0]      fetch_en_q;
  logic [NrCores-1:0]      wake_q;
  logic [31:0]             boot_addr_q;
  logic [31:0]             retcode_q;
  logic [SettleW-1:0]      settle_cnt_q;
  logic [TimeoutWidth-1:0] run_cnt_q;
  logic                    busy_q, done_q, err_q, timeout_flag_q, done_irq_q;

  logic [31:0]             cfg_boot_addr;
  logic [NrCores-1:0]      cfg_core_mask;
  logic [TimeoutWidth-1:0] cfg_timeout;
  logic                    start, abort;
  logic [31:0]             status;
  logic                    abort_hit, timeout_hit, complete_hit;

  konark_cluster_reg_if #(
    .NrCores      (NrCores),
    .TimeoutWidth (TimeoutWidth)
  ) u_reg_if (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .reg_req_valid_i (reg_req_valid_i),
    .reg_addr_i      (reg_addr_i),
    .reg_write_i     (reg_write_i),
    .reg_wdata_i     (reg_wdata_i),
    .reg_rsp_valid_o (reg_rsp_valid_o),
    .reg_rdata_o     (reg_rdata_o),
    .busy_i          (busy_q),
    .status_i        (status),
    .retcode_i       (retcode_q),
    .boot_addr_o     (cfg_boot_addr),
    .core_mask_o     (cfg_core_mask),
    .timeout_o       (cfg_timeout),
    .start_o         (start),
    .abort_o         (abort)
  );

  always_comb begin
    status = '0;
    status[STATUS_STATE_LSB +: 3] = state_q;
    status[STATUS_DONE_BIT]       = done_q;
    status[STATUS_ERR_BIT]        = err_q;
    status[STATUS_TIMEOUT_BIT]    = timeout_flag_q;
  end

  // The RUN phase lasts exactly cfg_timeout cycles before the timeout fires.
  assign abort_hit    = abort && busy_q;
  assign timeout_hit  = (state_q == ST_RUN) && (cfg_timeout != '0) &&
                        (run_cnt_q >= cfg_timeout - TimeoutWidth'(1));
  assign complete_hit = (state_q == ST_RUN) && ((eoc_i & mask_q) == mask_q);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      mask_q         <= '0;
      fetch_en_q     <= '0;
      wake_q         <= '0;
      boot_addr_q    <= '0;
      retcode_q      <= '0;
      settle_cnt_q   <= '0;
      run_cnt_q      <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      timeout_flag_q <= 1'b0;
      done_irq_q     <= 1'b0;
    end else begin
      done_irq_q <= 1'b0;
      wake_q     <= '0;
      // Abort outranks timeout, which outranks normal completion.
      if (abort_hit || timeout_hit || complete_hit) begin
        state_q        <= ST_DONE;
        busy_q         <= 1'b0;
        fetch_en_q     <= '0;
        done_q         <= 1'b1;
        done_irq_q     <= 1'b1;
        err_q          <= abort_hit || timeout_hit;
        timeout_flag_q <= !abort_hit && timeout_hit;
        if (!abort_hit && !timeout_hit) retcode_q <= eoc_code_i;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (start) begin
              timeout_flag_q <= 1'b0;
              if (cfg_core_mask == '0) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                err_q      <= 1'b1;
                done_irq_q <= 1'b1;
              end else begin
                state_q      <= ST_BOOT;
                busy_q       <= 1'b1;
                done_q       <= 1'b0;
                err_q        <= 1'b0;
                mask_q       <= cfg_core_mask;
                fetch_en_q   <= cfg_core_mask;
                boot_addr_q  <= cfg_boot_addr;
                settle_cnt_q <= '0;
              end
            end
          end
          ST_BOOT: begin
            if (settle_cnt_q == SettleLast) begin
              state_q <= ST_WAKE;
              wake_q  <= mask_q;
            end else begin
              settle_cnt_q <= settle_cnt_q + SettleW'(1);
            end
          end
          ST_WAKE: begin
            state_q   <= ST_RUN;
            run_cnt_q <= '0;
          end
          ST_RUN: begin
            if (run_cnt_q != '1) run_cnt_q <= run_cnt_q + TimeoutWidth'(1);
          end
          default: begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            fetch_en_q <= '0;
          end
        endcase
      end
    end
  end

  assign reg_req_ready_o = 1'b1;
  assign boot_addr_o     = boot_addr_q;
  assign fetch_en_o      = fetch_en_q;
  assign wake_o          = wake_q;
  assign busy_o          = busy_q;
  assign done_irq_o      = done_irq_q;

endmodule

// File: doc/konark_cluster_boot_ctrl.md
Name: konark_cluster_boot_ctrl

Overview:
- Sequences bring-up and completion of the cluster compute cores for the host.
- Host programs boot address and core mask over a simple 32-bit register port, then starts the run.
- Block asserts fetch enable, pulses per-core wake-ups, waits for end-of-computation from every selected core, then reports done, error and return code.
- Sits between the host/peripheral interconnect and the cluster's core control inputs.

Parameters:
- NrCores, 9, number of cores controlled (8 compute + 1 DMA).
- BootSettleCycles, 4, cycles fetch_en is held before wake pulses are issued (>=1).
- TimeoutWidth, 32, width of the RUN-phase timeout counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- reg_req_valid_i  in  1  register request valid
- reg_req_ready_o  out  1  register request ready; always 1
- reg_addr_i  in  5  byte address; bits [1:0] ignored
- reg_write_i  in  1  1 = write, 0 = read
- reg_wdata_i  in  32  write data
- reg_rsp_valid_o  out  1  response valid, exactly one cycle after an accepted request
- reg_rdata_o  out  32  read data; 0 for writes and unmapped addresses
- boot_addr_o  out  32  boot address to cores
- fetch_en_o  out  NrCores  per-core fetch enable
- wake_o  out  NrCores  per-core wake-up (software interrupt) pulse
- eoc_i  in  NrCores  per-core end-of-computation, level
- eoc_code_i  in  32  return code driven by core 0
- busy_o  out  1  high in BOOT, WAKE and RUN
- done_irq_o  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Clocking: single clock. Reset is synchronous and active-low on clk_i/rst_ni. Every flop is cleared when rst_ni is sampled low at a rising edge.
- Reset values: all outputs 0 except reg_req_ready_o = 1. Registers reset to 0; state = IDLE.
- Register map:
  - 0x00 BOOT_ADDR (RW)
  - 0x04 CORE_MASK (RW, low NrCores bits; upper bits read 0)
  - 0x08 CTRL (W; bit0 START, bit1 ABORT; reads 0)
  - 0x0C STATUS (RO; [2:0] state, [3] done, [4] err, [5] timeout)
  - 0x10 RETCODE (RO)
  - 0x14 TIMEOUT (RW; 0 = disabled)
- Writes to BOOT_ADDR, CORE_MASK or TIMEOUT while busy_o = 1 are dropped. A response is still returned.
- State encoding: IDLE=0, BOOT=1, WAKE=2, RUN=3, DONE=4.
- IDLE or DONE + START:
  - CORE_MASK == 0: go to DONE with err = 1.
  - Otherwise: clear done/err/timeout, latch the mask, go to BOOT.
- START while busy is ignored.
- BOOT:
  - fetch_en_o = latched mask; boot_addr_o = BOOT_ADDR. Both are held through RUN.
  - Stay exactly BootSettleCycles cycles, then go to WAKE.
- WAKE: wake_o = mask for exactly one cycle, then go to RUN; clear the timeout counter.
- RUN:
  - Leave when (eoc_i & mask) == mask: RETCODE <= eoc_code_i, go to DONE.
  - eoc_i bits outside the mask are ignored.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT: go to DONE with err = 1, timeout = 1.
  - The counter saturates and does not wrap.
- ABORT in BOOT, WAKE or RUN: go to DONE with err = 1.
- Priority within one cycle: ABORT > timeout > completion.
- ABORT in IDLE or DONE is ignored.
- DONE:
  - fetch_en_o = 0, done = 1, done_irq_o pulses on the entry cycle only.
  - A new START restarts the run.
- Simultaneous register write of START with a CORE_MASK write in the same transaction is impossible (single port). The mask latched is the register value at the START cycle.
- Reset mid-run: returns to IDLE next edge; fetch_en_o and wake_o drop immediately at that edge.

Decomposition:
- konark_cluster_pkg holds:
  - the state enum
  - register offset localparams
  - STATUS bit-position constants
  - a reg_req_t/reg_rsp_t struct pair
- One sub-module, konark_cluster_reg_if: register decode, read mux and the 1-cycle response. The FSM stays in the top block.

Test Plan:
- Program BOOT_ADDR=0x8000_0000, CORE_MASK=0x1FF, START. Expected:
  - fetch_en_o=0x1FF for 4 cycles before wake_o=0x1FF pulses once.
  - Raise eoc_i=0x1FF with eoc_code_i=0x2A: DONE, done_irq_o pulse, RETCODE=0x2A, STATUS err=0.
- CORE_MASK=0x003, START, eoc_i=0x1FC then 0x1FF. Expected: stays in RUN on 0x1FC; DONE only once bits 0–1 are set.
- TIMEOUT=10, CORE_MASK=0x001, START, never raise eoc. Expected: DONE 10 cycles after RUN entry; STATUS err=1, timeout=1.
- ABORT written in the same cycle the last eoc bit rises. Expected: err=1 and RETCODE unchanged.
- CORE_MASK=0 then START. Expected: immediate DONE with err=1; no fetch_en_o or wake_o activity.
- Write BOOT_ADDR=0x1234 during RUN; reset asserted mid-RUN. Expected:
  - BOOT_ADDR readback unchanged.
  - After reset, all outputs 0, state IDLE, registers 0.
